// File: rtl/core_pkg.sv
// Shared constants for the 5-stage core: forwarding select encodings,
// the PC register index and the register-address width.
package core_pkg;

    localparam int RA_W = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [RA_W-1:0] PC_REG = 4'd15;

    // M beats W; R15 reads always come from the PC path, never a bypass.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic            reg_write_m,
        input logic [RA_W-1:0] wa3_m,
        input logic            reg_write_w,
        input logic [RA_W-1:0] wa3_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra == PC_REG) begin
            sel = FWD_RF;
        end else if (reg_write_m && (ra == wa3_m)) begin
            sel = FWD_M;
        end else if (reg_write_w && (ra == wa3_w)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-unit signal bundle between the datapath (master) and the
// hazard controller (slave).
interface hazard_ctrl_if
    import core_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  RA1D;
    logic [RA_W-1:0]  RA2D;
    logic [RA_W-1:0]  RA1E;
    logic [RA_W-1:0]  RA2E;
    logic [RA_W-1:0]  WA3E;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             PCSrcD;
    logic             PCSrcE;
    logic             BranchTakenE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, RegWriteE, MemtoRegE,
               PCSrcD, PCSrcE, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               StallCnt, FlushCnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, RegWriteE, MemtoRegE,
               PCSrcD, PCSrcE, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stop at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows M/W write-back state, produces the
// ALU bypass selects and F/D/E stall/flush controls, and counts events.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    logic            reg_write_m_r;
    logic [RA_W-1:0] wa3_m_r;
    logic            pc_src_m_r;
    logic            reg_write_w_r;
    logic [RA_W-1:0] wa3_w_r;
    logic            pc_src_w_r;

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       ldr_stall_s;
    logic       pc_wr_pend_s;
    logic       stall_f_s;
    logic       stall_d_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic       flush_any_s;

    // Shadow M and W stage state; E inputs are already condition-gated.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m_r <= 1'b0;
            wa3_m_r       <= {RA_W{1'b0}};
            pc_src_m_r    <= 1'b0;
            reg_write_w_r <= 1'b0;
            wa3_w_r       <= {RA_W{1'b0}};
            pc_src_w_r    <= 1'b0;
        end else begin
            reg_write_m_r <= hz.RegWriteE;
            wa3_m_r       <= hz.WA3E;
            pc_src_m_r    <= hz.PCSrcE;
            reg_write_w_r <= reg_write_m_r;
            wa3_w_r       <= wa3_m_r;
            pc_src_w_r    <= pc_src_m_r;
        end
    end

    // Bypass selects and stall/flush controls, all zero while in reset.
    always_comb begin
        fwd_a_s      = FWD_RF;
        fwd_b_s      = FWD_RF;
        ldr_stall_s  = 1'b0;
        pc_wr_pend_s = 1'b0;
        stall_f_s    = 1'b0;
        stall_d_s    = 1'b0;
        flush_d_s    = 1'b0;
        flush_e_s    = 1'b0;
        if (reset) begin
            fwd_a_s   = FWD_RF;
            fwd_b_s   = FWD_RF;
            stall_f_s = 1'b0;
        end else begin
            fwd_a_s = fwd_sel(hz.RA1E, reg_write_m_r, wa3_m_r, reg_write_w_r, wa3_w_r);
            fwd_b_s = fwd_sel(hz.RA2E, reg_write_m_r, wa3_m_r, reg_write_w_r, wa3_w_r);
            ldr_stall_s  = hz.MemtoRegE & hz.RegWriteE &
                           ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
            pc_wr_pend_s = hz.PCSrcD | hz.PCSrcE | pc_src_m_r;
            stall_f_s    = ldr_stall_s | pc_wr_pend_s;
            stall_d_s    = ldr_stall_s;
            // StallD and FlushD may coincide; the F/D register lets flush win.
            flush_d_s    = pc_wr_pend_s | pc_src_w_r | hz.BranchTakenE;
            flush_e_s    = ldr_stall_s | hz.BranchTakenE;
        end
    end

    assign flush_any_s  = flush_d_s | flush_e_s;
    assign hz.ForwardAE = fwd_a_s;
    assign hz.ForwardBE = fwd_b_s;
    assign hz.StallF    = stall_f_s;
    assign hz.StallD    = stall_d_s;
    assign hz.FlushD    = flush_d_s;
    assign hz.FlushE    = flush_e_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_f_s),
        .count (hz.StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_any_s),
        .count (hz.FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against an instruction-history model.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    hazard_ctrl_if #(.CNT_W(16)) hif ();

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the instructions that left E one and two cycles ago.
    bit       m_valid_wr, w_valid_wr;
    bit [3:0] m_dst, w_dst;
    bit       m_pc, w_pc;
    int       exp_stall_cnt, exp_flush_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [3:0] ra);
        if (reset || ra == 4'd15) return 2'b00;
        if (m_valid_wr && ra == m_dst) return 2'b10;
        if (w_valid_wr && ra == w_dst) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_ldr();
        return !reset && hif.MemtoRegE && hif.RegWriteE &&
               (hif.RA1D == hif.WA3E || hif.RA2D == hif.WA3E);
    endfunction

    function automatic bit m_pcpend();
        return !reset && (hif.PCSrcD || hif.PCSrcE || m_pc);
    endfunction

    function automatic bit m_stall_f();
        return m_ldr() || m_pcpend();
    endfunction

    function automatic bit m_flush_d();
        return !reset && (m_pcpend() || w_pc || hif.BranchTakenE);
    endfunction

    function automatic bit m_flush_e();
        return !reset && (m_ldr() || hif.BranchTakenE);
    endfunction

    // Advance the instruction history and the expected counters at each edge.
    always @(posedge clk) begin
        if (reset) begin
            m_valid_wr <= 1'b0; m_dst <= 4'd0; m_pc <= 1'b0;
            w_valid_wr <= 1'b0; w_dst <= 4'd0; w_pc <= 1'b0;
            exp_stall_cnt <= 0;
            exp_flush_cnt <= 0;
        end else begin
            if (m_stall_f() && exp_stall_cnt < 65535) exp_stall_cnt <= exp_stall_cnt + 1;
            if ((m_flush_d() || m_flush_e()) && exp_flush_cnt < 65535)
                exp_flush_cnt <= exp_flush_cnt + 1;
            w_valid_wr <= m_valid_wr; w_dst <= m_dst; w_pc <= m_pc;
            m_valid_wr <= hif.RegWriteE; m_dst <= hif.WA3E; m_pc <= hif.PCSrcE;
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        check("ForwardAE", {30'd0, hif.ForwardAE}, {30'd0, m_fwd(hif.RA1E)});
        check("ForwardBE", {30'd0, hif.ForwardBE}, {30'd0, m_fwd(hif.RA2E)});
        check("StallF", {31'd0, hif.StallF}, {31'd0, m_stall_f()});
        check("StallD", {31'd0, hif.StallD}, {31'd0, m_ldr()});
        check("FlushD", {31'd0, hif.FlushD}, {31'd0, m_flush_d()});
        check("FlushE", {31'd0, hif.FlushE}, {31'd0, m_flush_e()});
        check("StallCnt", {16'd0, hif.StallCnt}, exp_stall_cnt);
        check("FlushCnt", {16'd0, hif.FlushCnt}, exp_flush_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.RA1D = 4'd0; hif.RA2D = 4'd0; hif.RA1E = 4'd0; hif.RA2E = 4'd0;
        hif.WA3E = 4'd0; hif.RegWriteE = 1'b0; hif.MemtoRegE = 1'b0;
        hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0; hif.BranchTakenE = 1'b0;
    endtask

    function automatic logic [3:0] rnd_ra();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    // Directed scenarios, randomized traffic, then counter saturation.
    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        idle();
        tick();
        tick();
        hif.PCSrcD = 1'b1;
        #3 check("reset_stallf", {31'd0, hif.StallF}, 32'd0);
        idle();
        tick();
        reset = 1'b0;

        // ALU back-to-back: M bypass then W bypass.
        hif.RegWriteE = 1'b1; hif.WA3E = 4'd3;
        tick();
        idle(); hif.RA1E = 4'd3;
        #3 check("alu_fwd_m", {30'd0, hif.ForwardAE}, 32'd2);
        tick();
        hif.RA1E = 4'd3;
        #3 check("alu_fwd_w", {30'd0, hif.ForwardAE}, 32'd1);
        tick();

        // Load-use: one bubble, then the load bypasses from W.
        idle();
        hif.MemtoRegE = 1'b1; hif.RegWriteE = 1'b1; hif.WA3E = 4'd2; hif.RA2D = 4'd2;
        #3 check("ldr_ctrl", {28'd0, hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}, 32'hD);
        tick();
        idle();
        #3 check("ldr_stallcnt", {16'd0, hif.StallCnt}, 32'd1);
        tick();
        hif.RA2E = 4'd2;
        #3 check("ldr_fwd_w", {30'd0, hif.ForwardBE}, 32'd1);
        tick();

        // Condition-failed write must not bypass.
        idle(); hif.WA3E = 4'd5;
        tick();
        idle(); hif.RA1E = 4'd5;
        #3 check("cond_fail_fwd", {30'd0, hif.ForwardAE}, 32'd0);
        tick();

        // Taken branch.
        idle(); hif.BranchTakenE = 1'b1;
        #3 check("br_ctrl", {28'd0, hif.StallF, hif.StallD, hif.FlushD, hif.FlushE}, 32'h3);
        tick();
        idle();
        #3 check("br_flushcnt", {16'd0, hif.FlushCnt}, 32'd2);

        // PC-writing instruction through D, E, M, W.
        hif.PCSrcD = 1'b1;
        #3 check("pc_d", {30'd0, hif.StallF, hif.FlushD}, 32'h3);
        tick();
        idle(); hif.PCSrcE = 1'b1;
        #3 check("pc_e", {30'd0, hif.StallF, hif.FlushD}, 32'h3);
        tick();
        idle();
        #3 check("pc_m", {30'd0, hif.StallF, hif.FlushD}, 32'h3);
        tick();
        #3 check("pc_w", {30'd0, hif.StallF, hif.FlushD}, 32'h1);
        tick();
        #3 check("pc_cnts", {hif.StallCnt, hif.FlushCnt}, {16'd4, 16'd6});

        // Reset mid-operation.
        hif.RegWriteE = 1'b1; hif.WA3E = 4'd7;
        tick();
        idle(); hif.PCSrcD = 1'b1; hif.RA1E = 4'd7; reset = 1'b1;
        #3 check("rst_outs", {24'd0, hif.ForwardAE, hif.ForwardBE, hif.StallF,
                              hif.StallD, hif.FlushD, hif.FlushE}, 32'd0);
        tick();
        reset = 1'b0; hif.PCSrcD = 1'b0;
        #3 check("rst_nofwd", {30'd0, hif.ForwardAE}, 32'd0);
        check("rst_cnts", {hif.StallCnt, hif.FlushCnt}, 32'd0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            hif.RA1D = rnd_ra(); hif.RA2D = rnd_ra();
            hif.RA1E = rnd_ra(); hif.RA2E = rnd_ra();
            hif.WA3E = rnd_ra();
            hif.RegWriteE    = 1'($urandom_range(0, 1));
            hif.MemtoRegE    = ($urandom_range(0, 3) == 0);
            hif.PCSrcD       = ($urandom_range(0, 9) == 0);
            hif.PCSrcE       = ($urandom_range(0, 9) == 0);
            hif.BranchTakenE = ($urandom_range(0, 9) == 0);
            reset            = ($urandom_range(0, 49) == 0);
            tick();
        end

        // Stall counter saturation.
        idle(); reset = 1'b1;
        tick();
        reset = 1'b0; hif.PCSrcD = 1'b1;
        repeat (65534) tick();
        #3 check("sat_fffe", {16'd0, hif.StallCnt}, 32'h0000FFFE);
        repeat (3) tick();
        #3 check("sat_ffff", {16'd0, hif.StallCnt}, 32'h0000FFFF);
        idle();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
